// File: rtl/calculator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calculator_pkg
// Description : Shared sizing constants and the memory-responder state type
//               for the calculator memory slice.
// Revision    : 1.0 - initial release
// ============================================================================
package calculator_pkg;

  // Address width; the responder memory holds 2**ADDR_W words.
  localparam int ADDR_W        = 4;
  // Width of one memory word in bits.
  localparam int MEM_WORD_SIZE = 64;

  // Responder FSM: S_INIT sweeps zeros through the array, S_SERVE accepts requests.
  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_SERVE = 1'b1
  } mem_state_t;

endpackage : calculator_pkg
`default_nettype wire

// File: rtl/sram_1r1w.sv
`default_nettype none
// ============================================================================
// Module      : sram_1r1w
// Description : Synchronous 1-read/1-write storage array with registered read
//               data and no reset. A read and a write to the same address in
//               the same cycle return the old word (read-before-write).
// Ports       : clk_i    - clock, rising edge
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
//               re_i     - read enable; rdata_o holds when low
//               raddr_i  - read address
//               rdata_o  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1r1w #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sram_1r1w
`default_nettype wire

// File: rtl/calc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : calc_mem_responder
// Description : Memory responder. After reset it zeroes every word of its
//               array (one word per cycle), then serves 1-cycle-latency reads
//               and single-cycle writes. Requests arriving before the array
//               is ready are dropped and flagged on a sticky error bit.
// Ports       : clk_i   - clock, rising edge
//               rst_i   - asynchronous active-high reset
//               write   - write request      w_addr/w_data - write address/data
//               read    - read request       r_addr        - read address
//               r_data  - registered read data (0 until the first read)
//               r_valid - r_data answers the read accepted on the previous edge
//               ready   - requests are accepted
//               req_err - sticky: a request arrived while ready was low
// Revision    : 1.0 - initial release
// ============================================================================
module calc_mem_responder
  import calculator_pkg::*;
#(
  parameter int ADDR_W        = calculator_pkg::ADDR_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [MEM_WORD_SIZE-1:0] w_data,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        r_addr,
  output logic [MEM_WORD_SIZE-1:0] r_data,
  output logic                     r_valid,
  output logic                     ready,
  output logic                     req_err
);

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = {ADDR_W{1'b1}};

  mem_state_t              state_q, state_d;
  logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic                    ready_q, ready_d;
  logic                    r_valid_q, r_valid_d;
  logic                    req_err_q, req_err_d;
  // Set by the first accepted read; until then r_data reads as zero because
  // the array's read register itself has no reset.
  logic                    has_rd_q, has_rd_d;

  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [MEM_WORD_SIZE-1:0] mem_wdata;
  logic                     mem_re;
  logic [MEM_WORD_SIZE-1:0] mem_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      r_valid_q <= 1'b0;
      req_err_q <= 1'b0;
      has_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      r_valid_q <= r_valid_d;
      req_err_q <= req_err_d;
      has_rd_q  <= has_rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wdata = w_data;
    mem_re    = 1'b0;

    case (state_q)
      S_INIT: begin
        // Sweep owns the write port; the counter parks on the last address.
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (clr_cnt_q == C_LAST_ADDR) begin
          state_d = S_SERVE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_SERVE: begin
        mem_we = write;
        mem_re = read;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // ready is registered from the next state so it carries no input path.
    ready_d   = (state_d == S_SERVE);
    r_valid_d = mem_re;
    has_rd_d  = has_rd_q | mem_re;
    req_err_d = req_err_q | ((state_q == S_INIT) & (write | read));
  end

  sram_1r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (MEM_WORD_SIZE)
  ) u_sram (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (r_addr),
    .rdata_o (mem_rdata)
  );

  assign r_data  = has_rd_q ? mem_rdata : '0;
  assign r_valid = r_valid_q;
  assign ready   = ready_q;
  assign req_err = req_err_q;

endmodule : calc_mem_responder
`default_nettype wire

// File: tb/tb_calc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_mem_responder
// Description : Self-checking bench for calc_mem_responder (ADDR_W=4, 64-bit
//               words). Read expectations go into a queue when the read is
//               driven and are compared when r_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_mem_responder;

  localparam int AW = 4;
  localparam int DW = 64;

  logic          clk_i  = 1'b0;
  logic          rst_i  = 1'b1;
  logic          write  = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          read   = 1'b0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          ready;
  logic          req_err;

  calc_mem_responder #(
    .ADDR_W        (AW),
    .MEM_WORD_SIZE (DW)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .write   (write),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .read    (read),
    .r_addr  (r_addr),
    .r_data  (r_data),
    .r_valid (r_valid),
    .ready   (ready),
    .req_err (req_err)
  );

  always #5 clk_i = ~clk_i;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            valid_seen = 0;
  logic [DW-1:0] exp_q [$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rd;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every r_valid cycle must consume one queued expectation.
  always @(negedge clk_i) begin
    if (r_valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_rvalid: got r_valid=1 r_data=%h, want no response", r_data);
      end else begin
        chk("r_data", r_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rd, input logic [AW-1:0] ra, input logic [DW-1:0] expd);
    write  = wr;
    w_addr = wa;
    w_data = wd;
    read   = rd;
    r_addr = ra;
    if (rd) exp_q.push_back(expd);
  endtask

  task automatic idle();
    write = 1'b0;
    read  = 1'b0;
  endtask

  // Counts edges (continuing from 'start') until ready rises, bounded at 40.
  task automatic wait_ready(input string name, input int start, input int want);
    int n;
    n = start;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(name, DW'(n), DW'(want));
  endtask

  initial begin
    int v0;
    tbl[0] = '{1'b1, 4'd5,  64'hDEAD_BEEF_0000_0001, 1'b0, 4'd0,  64'h0};
    tbl[1] = '{1'b0, 4'd0,  64'h0,                   1'b1, 4'd5,  64'hDEAD_BEEF_0000_0001};
    tbl[2] = '{1'b1, 4'd3,  64'h11,                  1'b0, 4'd0,  64'h0};
    tbl[3] = '{1'b1, 4'd3,  64'h22,                  1'b1, 4'd3,  64'h11};
    tbl[4] = '{1'b0, 4'd0,  64'h0,                   1'b1, 4'd3,  64'h22};
    tbl[5] = '{1'b1, 4'd7,  64'hAAAA_5555,           1'b1, 4'd2,  64'h0};
    tbl[6] = '{1'b0, 4'd0,  64'h0,                   1'b1, 4'd7,  64'hAAAA_5555};
    tbl[7] = '{1'b1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0,  64'h0};
    tbl[8] = '{1'b0, 4'd0,  64'h0,                   1'b1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[9] = '{1'b0, 4'd0,  64'h0,                   1'b0, 4'd0,  64'h0};

    // Reset state
    repeat (3) tick();
    chk("rst_ready",   DW'(ready),   '0);
    chk("rst_rvalid",  DW'(r_valid), '0);
    chk("rst_rdata",   r_data,       '0);
    chk("rst_req_err", DW'(req_err), '0);

    // Release: ready after exactly 16 edges, whole array reads zero
    rst_i = 1'b0;
    wait_ready("ready_after_release", 0, 16);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), '0);
      tick();
      chk("clear_rvalid", DW'(r_valid), 64'd1);
    end
    idle();

    // Table: write/read, collision, different-address concurrency, boundaries
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra, tbl[i].exp);
      tick();
      chk($sformatf("tbl%0d_rvalid", i), DW'(r_valid), DW'(tbl[i].rd));
    end
    idle();

    // No read: r_valid low, r_data holds the last word
    tick();
    chk("hold_rvalid", DW'(r_valid), '0);
    chk("hold_rdata",  r_data,       64'hFFFF_FFFF_FFFF_FFFF);

    // Streaming: preload index values, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, AW'(i), DW'(i), 1'b0, '0, '0);
      tick();
    end
    idle();
    v0 = valid_seen;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), DW'(i));
      tick();
      chk("stream_rvalid", DW'(r_valid), 64'd1);
    end
    idle();
    tick();
    chk("stream_count", DW'(valid_seen - v0), 64'd16);

    // Reset while a read response is showing: outputs clear immediately
    drive(1'b0, '0, '0, 1'b1, 4'd4, 64'd4);
    tick();
    chk("inflight_rvalid", DW'(r_valid), 64'd1);
    rst_i = 1'b1;
    idle();
    #1;
    chk("async_rvalid", DW'(r_valid), '0);
    chk("async_ready",  DW'(ready),   '0);
    chk("async_rdata",  r_data,       '0);
    exp_q.delete();
    tick();
    tick();

    // Early request two edges after release: dropped, sticky error
    rst_i = 1'b0;
    tick();
    tick();
    drive(1'b0, '0, '0, 1'b1, 4'd0, '0);
    exp_q.delete();
    tick();
    idle();
    chk("early_rvalid",  DW'(r_valid), '0);
    chk("early_req_err", DW'(req_err), 64'd1);
    wait_ready("early_ready", 3, 16);
    chk("early_err_sticky", DW'(req_err), 64'd1);

    // Put a value at address 9 so the later re-sweep is observable
    drive(1'b1, 4'd9, 64'h99, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 4'd9, 64'h99);
    tick();
    chk("a9_rvalid", DW'(r_valid), 64'd1);
    idle();
    tick();

    // Mid-sweep reset at sweep cycle 8, then a full restart
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (8) tick();
    chk("midsweep_err_cleared", DW'(req_err), '0);
    rst_i = 1'b1;
    #1;
    chk("midsweep_ready",  DW'(ready),   '0);
    chk("midsweep_rvalid", DW'(r_valid), '0);
    tick();
    rst_i = 1'b0;
    wait_ready("midsweep_ready_rise", 0, 16);
    drive(1'b0, '0, '0, 1'b1, 4'd9, '0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 4'd15, '0);
    tick();
    idle();
    tick();
    tick();
    chk("queue_drained", DW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no summary, want completion before 100000 time units");
    $fatal(1);
  end

endmodule : tb_calc_mem_responder
`default_nettype wire

// File: doc/calc_mem_responder.md
CALC_MEM_RESPONDER -- requirements
Module: calc_mem_responder

Interface
REQ-001 Parameter ADDR_W: SHALL default to calculator_pkg::ADDR_W; it is the address width, and depth = 2**ADDR_W words.
REQ-002 Parameter MEM_WORD_SIZE: SHALL default to calculator_pkg::MEM_WORD_SIZE; it is the word width in bits.
REQ-003 Port clk_i: input, 1 bit; the single clock, rising edge.
REQ-004 Port rst_i: input, 1 bit; reset, asynchronous and active-high.
REQ-005 Port write: input, 1 bit; write request, sampled each rising edge.
REQ-006 Port w_addr: input, ADDR_W bits; write address.
REQ-007 Port w_data: input, MEM_WORD_SIZE bits; write data.
REQ-008 Port read: input, 1 bit; read request, sampled each rising edge.
REQ-009 Port r_addr: input, ADDR_W bits; read address.
REQ-010 Port r_data: output, MEM_WORD_SIZE bits; registered read data.
REQ-011 Port r_valid: output, 1 bit; r_data holds the response to the read accepted on the previous edge.
REQ-012 Port ready: output, 1 bit; requests are accepted.
REQ-013 Port req_err: output, 1 bit; sticky flag meaning a request arrived while ready=0.

Function
REQ-014 The FSM SHALL have exactly two states, S_INIT and S_SERVE, and SHALL enter S_INIT on reset.
REQ-015 In S_INIT: a clear counter SHALL run 0..depth-1 and write zero to one word per cycle, taking depth cycles in total.
REQ-016 In S_INIT: when the counter write to depth-1 completes, the FSM SHALL move to S_SERVE on that edge.
REQ-017 ready SHALL be 1 exactly when state == S_SERVE, driven from a register with no combinational path from inputs.
REQ-018 In S_INIT: write and read SHALL be ignored (no memory update, r_valid=0), and either one asserted SHALL set req_err.
REQ-019 In S_SERVE: write=1 SHALL store w_data at w_addr on that edge.
REQ-020 In S_SERVE: read=1 SHALL load mem[r_addr] into r_data on that edge and set r_valid=1 for the following cycle, giving 1-cycle latency.
REQ-021 In S_SERVE: with read=0, r_valid SHALL be 0 and r_data SHALL hold its last value.
REQ-022 Back-to-back reads on consecutive cycles SHALL each produce one r_valid cycle, giving full throughput.
REQ-023 Simultaneous read and write to the same address SHALL be read-before-write: r_data returns the old word, and the new word is visible from the next read.
REQ-024 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-025 Addresses SHALL be full-range with no out-of-range case, and the clear counter SHALL not wrap past depth-1.
REQ-026 Once set, req_err SHALL stay set until reset.

Reset
REQ-027 rst_i=1 SHALL asynchronously force state=S_INIT, clear counter=0, ready=0, r_valid=0, r_data=0 and req_err=0.
REQ-028 Reset asserted mid-operation, including mid-sweep, SHALL abort any in-flight read (no r_valid) and restart the full clear sweep after deassertion.
REQ-029 Memory array contents SHALL not be reset directly, and SHALL be zeroed only by the sweep.

Structure
REQ-030 ADDR_W, MEM_WORD_SIZE and the state enum type mem_state_t (S_INIT, S_SERVE) SHALL live in calculator_pkg.
REQ-031 The storage array SHALL be one sub-module, sram_1r1w: a synchronous 1-read/1-write array with registered read and no reset.
REQ-032 calc_mem_responder SHALL own the FSM, the clear counter, the write mux (sweep vs. request), r_valid and req_err.

Verification (bench uses ADDR_W=4, MEM_WORD_SIZE=64)
REQ-033 Reset release: deassert rst_i and wait -> ready rises exactly 16 cycles later; reading all 16 addresses returns 64'h0 each.
REQ-034 Write then read: write 64'hDEAD_BEEF_0000_0001 to address 5, then read address 5 next cycle -> r_valid=1 one cycle after the read, r_data=64'hDEAD_BEEF_0000_0001.
REQ-035 Collision: address 3 holds 64'h11; same cycle, write 64'h22 to address 3 and read address 3 -> r_data=64'h11; a following read of address 3 -> 64'h22.
REQ-036 Early request: assert read at address 0 two cycles after reset release -> no r_valid, req_err=1 and stays 1; ready still rises at cycle 16.
REQ-037 Mid-sweep reset: assert rst_i at sweep cycle 8 -> ready=0 and r_valid=0 immediately; after release, ready rises 16 cycles later.
REQ-038 Streaming: reads of addresses 0..15 on consecutive cycles, after preload of each word with its index -> r_valid high for 16 consecutive cycles, r_data=0..15 in order.
